// File: rtl/tpg_pkg.sv
// Shared definitions for the test pattern generator.
// Contents:
//   state_t  - FSM state encoding (IDLE, RUN, DONE)
//   tap_poly - maximal-length polynomial exponents per width (2..32)
//   tap_mask - feedback tap mask for a left-shifting LFSR of a given width
package tpg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MIN_BITS = 2;
    localparam int MAX_BITS = 32;

    // Inner exponents of a primitive polynomial x^n + ... + 1 for each width.
    // Bit e set means the term x^e is present (0 < e < n).
    function automatic logic [31:0] tap_poly(input int n);
        logic [31:0] p;
        case (n)
            2:       p = 32'h0000_0002;
            3:       p = 32'h0000_0004;
            4:       p = 32'h0000_0008;
            5:       p = 32'h0000_0008;
            6:       p = 32'h0000_0020;
            7:       p = 32'h0000_0040;
            8:       p = 32'h0000_0070;
            9:       p = 32'h0000_0020;
            10:      p = 32'h0000_0080;
            11:      p = 32'h0000_0200;
            12:      p = 32'h0000_0052;
            13:      p = 32'h0000_001A;
            14:      p = 32'h0000_002A;
            15:      p = 32'h0000_4000;
            16:      p = 32'h0000_A010;
            17:      p = 32'h0000_4000;
            18:      p = 32'h0000_0800;
            19:      p = 32'h0000_0046;
            20:      p = 32'h0002_0000;
            21:      p = 32'h0008_0000;
            22:      p = 32'h0020_0000;
            23:      p = 32'h0004_0000;
            24:      p = 32'h00C2_0000;
            25:      p = 32'h0040_0000;
            26:      p = 32'h0000_0046;
            27:      p = 32'h0000_0026;
            28:      p = 32'h0200_0000;
            29:      p = 32'h0800_0000;
            30:      p = 32'h0000_0052;
            31:      p = 32'h1000_0000;
            32:      p = 32'h0040_0006;
            default: p = 32'h0000_0000;
        endcase
        return p;
    endfunction

    // The pattern shifts left and the feedback enters at bit 0, so pat[n-1]
    // is the oldest sequence element.  That makes pat[n-1] the constant term
    // of the recurrence and an exponent e map to bit n-1-e.  For n=4 this
    // yields taps {3,0}: fb = pat[3]^pat[0].
    function automatic logic [31:0] tap_mask(input int n);
        logic [31:0] poly;
        logic [31:0] mask;
        mask = 32'h0;
        if (n >= MIN_BITS && n <= MAX_BITS) begin
            poly = tap_poly(n);
            mask[n-1] = 1'b1;
            for (int e = 1; e < n; e++) begin
                if (poly[e]) begin
                    mask[n-1-e] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/tpg_lfsr.sv
// Combinational next-pattern logic of the LFSR.
// Ports:
//   cur - current pattern
//   nxt - {cur[IN_BITS-2:0], fb}, fb = XOR of the tap bits for IN_BITS
module tpg_lfsr
    import tpg_pkg::*;
#(
    parameter int IN_BITS = 4
) (
    input  logic [IN_BITS-1:0] cur,
    output logic [IN_BITS-1:0] nxt
);

    localparam logic [31:0]        MASK_FULL = tap_mask(IN_BITS);
    localparam logic [IN_BITS-1:0] MASK      = MASK_FULL[IN_BITS-1:0];

    logic fb;

    assign fb  = ^(cur & MASK);
    assign nxt = {cur[IN_BITS-2:0], fb};

endmodule

// File: rtl/tpg.sv
// Test pattern generator: runs one LFSR session of n_pat patterns per start.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - session request, sampled only in IDLE
//   seed      - LFSR seed, captured with start (all-zero replaced by 1)
//   n_pat     - pattern count, captured with start
//   pat       - registered pattern to the CUT
//   pat_valid - pat belongs to the current session
//   busy      - high in RUN and DONE
//   done      - one-cycle pulse at session end
//   state     - current FSM state (debug observation)
//
// Start protocol: start is a level request honoured on any rising edge where
// the FSM is in IDLE; busy is high from the following cycle until the session
// ends, and start is ignored while busy. A start held high re-launches a
// session on the first edge after IDLE is re-entered.
module tpg
    import tpg_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_BITS-1:0]  seed,
    input  logic [CNT_BITS-1:0] n_pat,
    output logic [IN_BITS-1:0]  pat,
    output logic                pat_valid,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state
);

    state_t                state_q;
    logic [CNT_BITS-1:0]   cnt;
    logic [IN_BITS-1:0]    pat_next;
    logic [IN_BITS-1:0]    eff_seed;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    assign eff_seed = (seed == '0) ? {{(IN_BITS-1){1'b0}}, 1'b1} : seed;

    tpg_lfsr #(
        .IN_BITS (IN_BITS)
    ) u_lfsr (
        .cur (pat),
        .nxt (pat_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pat       <= '0;
            cnt       <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat  <= eff_seed;
                        cnt  <= n_pat;
                        busy <= 1'b1;
                        if (n_pat == '0) begin
                            // Empty session: straight to the done pulse.
                            state_q   <= ST_DONE;
                            pat_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_q   <= ST_RUN;
                            pat_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    pat <= pat_next;
                    cnt <= cnt - 1'b1;
                    // The pattern on pat now is the last one of the session.
                    if (cnt == CNT_BITS'(1)) begin
                        state_q   <= ST_DONE;
                        pat_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pat_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_tpg.sv
// Directed bench for tpg (IN_BITS=4, CNT_BITS=8).
module tb_tpg;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] seed;
    logic [7:0] n_pat;
    logic [3:0] pat;
    logic       pat_valid;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference maximal-length sequence starting at 0001.
    logic [3:0] seq [15];

    typedef struct {
        logic [3:0] seed;
        logic [7:0] n_pat;
        int         exp_len;
        logic [3:0] exp_first;
        logic [3:0] exp_last;
        logic [3:0] exp_hold;
    } vec_t;

    vec_t vecs [7];

    tpg #(
        .IN_BITS  (4),
        .CNT_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .n_pat     (n_pat),
        .pat       (pat),
        .pat_valid (pat_valid),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int seq_index(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 15; i++) begin
            if (seq[i] == v) r = i;
        end
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    // mode 0: start for one cycle, then scramble seed/n_pat
    // mode 1: start pulsed again after the 2nd pattern
    // mode 2: start held high throughout
    task automatic run_session(input logic [3:0] s, input logic [7:0] n, input int mode,
                               output int nvalid, output logic [3:0] first_p,
                               output logic [3:0] last_p);
        int idx;
        int cyc;
        bit fin;
        idx   = seq_index((s == 4'd0) ? 4'd1 : s);
        seed  = s;
        n_pat = n;
        start = 1'b1;
        next_cycle();
        if (mode == 0) begin
            start = 1'b0;
            seed  = ~s;
            n_pat = 8'hA5;
        end else if (mode == 1) begin
            start = 1'b0;
        end
        nvalid  = 0;
        cyc     = 0;
        fin     = 1'b0;
        first_p = 4'd0;
        last_p  = 4'd0;
        while (!fin && cyc < 400) begin
            if (pat_valid) begin
                check("pat_seq", {28'd0, pat}, {28'd0, seq[(idx + nvalid) % 15]});
                check("busy_run", {31'd0, busy}, 32'd1);
                if (nvalid == 0) first_p = pat;
                last_p = pat;
                nvalid++;
            end
            if (done) begin
                check("valid_in_done", {31'd0, pat_valid}, 32'd0);
                check("busy_in_done", {31'd0, busy}, 32'd1);
                fin = 1'b1;
            end
            if (mode == 1) start = (nvalid == 2);
            next_cycle();
            cyc++;
        end
        check("session_end", {31'd0, fin}, 32'd1);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("state_idle", {30'd0, state}, 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        int         nv;
        int         cnt;
        bit         fin;
        logic [3:0] fp;
        logic [3:0] lp;

        seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

        vecs[0] = '{seed: 4'h1, n_pat: 8'd15, exp_len: 15, exp_first: 4'h1, exp_last: 4'h8, exp_hold: 4'h1};
        vecs[1] = '{seed: 4'h0, n_pat: 8'd3,  exp_len: 3,  exp_first: 4'h1, exp_last: 4'h7, exp_hold: 4'hF};
        vecs[2] = '{seed: 4'h8, n_pat: 8'd1,  exp_len: 1,  exp_first: 4'h8, exp_last: 4'h8, exp_hold: 4'h1};
        vecs[3] = '{seed: 4'h5, n_pat: 8'd4,  exp_len: 4,  exp_first: 4'h5, exp_last: 4'hC, exp_hold: 4'h9};
        vecs[4] = '{seed: 4'hF, n_pat: 8'd2,  exp_len: 2,  exp_first: 4'hF, exp_last: 4'hE, exp_hold: 4'hD};
        vecs[5] = '{seed: 4'h9, n_pat: 8'd5,  exp_len: 5,  exp_first: 4'h9, exp_last: 4'h1, exp_hold: 4'h3};
        vecs[6] = '{seed: 4'h6, n_pat: 8'd0,  exp_len: 0,  exp_first: 4'h0, exp_last: 4'h0, exp_hold: 4'h6};

        // reset
        rst   = 1'b0;
        start = 1'b0;
        seed  = 4'h0;
        n_pat = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_pat", {28'd0, pat}, 32'd0);
        check("rst_valid", {31'd0, pat_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        rst = 1'b1;
        next_cycle();

        // table-driven sessions
        for (int v = 0; v < 7; v++) begin
            run_session(vecs[v].seed, vecs[v].n_pat, 0, nv, fp, lp);
            check($sformatf("v%0d_len", v), nv, vecs[v].exp_len);
            if (vecs[v].exp_len > 0) begin
                check($sformatf("v%0d_first", v), {28'd0, fp}, {28'd0, vecs[v].exp_first});
                check($sformatf("v%0d_last", v), {28'd0, lp}, {28'd0, vecs[v].exp_last});
            end
            check($sformatf("v%0d_hold", v), {28'd0, pat}, {28'd0, vecs[v].exp_hold});
            next_cycle();
            check($sformatf("v%0d_hold2", v), {28'd0, pat}, {28'd0, vecs[v].exp_hold});
        end

        // start re-pulsed mid-run is ignored
        run_session(4'h1, 8'd5, 1, nv, fp, lp);
        check("poke_len", nv, 5);
        check("poke_last", {28'd0, lp}, 32'hE);
        next_cycle();
        check("poke_no_restart", {31'd0, pat_valid}, 32'd0);

        // start held high: next session two cycles after done
        run_session(4'h3, 8'd5, 2, nv, fp, lp);
        check("hold_len", nv, 5);
        check("hold_idle_valid", {31'd0, pat_valid}, 32'd0);
        check("hold_idle_pat", {28'd0, pat}, 32'hA);
        next_cycle();
        check("hold_restart_valid", {31'd0, pat_valid}, 32'd1);
        check("hold_restart_pat", {28'd0, pat}, 32'h3);
        start = 1'b0;
        cnt = 1;
        fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            next_cycle();
            if (pat_valid) cnt++;
            if (done) fin = 1'b1;
        end
        check("hold_second_end", {31'd0, fin}, 32'd1);
        check("hold_second_len", cnt, 5);
        next_cycle();

        // asynchronous reset mid-session
        seed  = 4'h1;
        n_pat = 8'd10;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        check("pre_rst_pat3", {28'd0, pat}, 32'h7);
        check("pre_rst_valid", {31'd0, pat_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_pat", {28'd0, pat}, 32'd0);
        check("arst_valid", {31'd0, pat_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_state", {30'd0, state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_session(4'h8, 8'd3, 0, nv, fp, lp);
        check("post_rst_first", {28'd0, fp}, 32'h8);
        check("post_rst_len", nv, 3);
        check("post_rst_last", {28'd0, lp}, 32'h3);
        next_cycle();

        // full 8-bit count, sequence wraps every 15
        run_session(4'h1, 8'd255, 0, nv, fp, lp);
        check("long_len", nv, 255);
        check("long_first", {28'd0, fp}, 32'h1);
        check("long_last", {28'd0, lp}, 32'h8);
        next_cycle();
        check("long_single_done", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpg.md
TPG -- requirements
Module: tpg

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 4, giving the pattern width driven to the CUT inputs (legal 2..32).
REQ-002 The block SHALL have parameter CNT_BITS, default 8, giving the width of the pattern-count input.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request to run one test session; sampled only in IDLE.
REQ-006 The block SHALL have port seed  input  IN_BITS  LFSR seed; captured with start.
REQ-007 The block SHALL have port n_pat  input  CNT_BITS  number of patterns in the session; captured with start.
REQ-008 The block SHALL have port pat  output  IN_BITS  registered test pattern to the CUT and the fault-free model.
REQ-009 The block SHALL have port pat_valid  output  1  high while pat holds a pattern of the current session.
REQ-010 The block SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking session end.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL load pat with the effective seed, load the counter with n_pat, and enter RUN, or enter DONE directly if n_pat=0.
REQ-014 The effective seed SHALL be seed, or 1 when seed is all-zero, so that the LFSR never locks up.
REQ-015 In RUN, pat_valid SHALL be 1 and pat SHALL hold the current pattern, the first being the effective seed in the cycle after start is sampled.
REQ-016 At each RUN edge, pat SHALL advance to {pat[IN_BITS-2:0], fb} and the counter SHALL decrement by one.
REQ-017 fb SHALL be the XOR of the tap bits of the maximal-length polynomial for IN_BITS; for IN_BITS=4, fb = pat[3]^pat[0].
REQ-018 When the counter equals 1 at a RUN edge, the FSM SHALL enter DONE, so exactly n_pat cycles have pat_valid=1.
REQ-019 In DONE, done SHALL be 1 and pat_valid SHALL be 0 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-020 start SHALL be ignored in RUN and DONE, and a start held high SHALL begin a new session only after IDLE is re-entered.
REQ-021 In IDLE and DONE, pat SHALL hold its last value.
REQ-022 Changes to seed or n_pat after capture SHALL have no effect on the running session.
REQ-023 n_pat=2^CNT_BITS-1 SHALL run the full count with no wrap, and the sequence SHALL repeat with period 2^IN_BITS-1 if the session is longer.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, pat=0, counter=0, pat_valid=0, busy=0 and done=0, including mid-session.
REQ-025 After rst deasserts, the block SHALL respond to the first start sampled at a rising edge.

Structure
REQ-026 A shared package tpg_pkg SHALL hold the FSM state encoding and a tap-mask table or function indexed by width (2..32).
REQ-027 The next-state feedback logic SHALL be one combinational sub-module, lfsr, parameterised by IN_BITS.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.

Verification
REQ-029 IN_BITS=4, seed=0001, n_pat=15 -> pat = 0001,0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000 with pat_valid high for exactly those 15 cycles, then done pulses once.
REQ-030 seed=0000, n_pat=3 -> pat = 0001,0011,0111, then done.
REQ-031 n_pat=0 with start -> no pat_valid, done pulses in the cycle after start is sampled, busy high for one cycle.
REQ-032 start pulsed again during RUN of n_pat=5 -> exactly 5 patterns; with start held high, a second session starts two cycles after done.
REQ-033 rst=0 after the 3rd pattern of an n_pat=10 session -> all outputs 0 asynchronously; a new start with seed=1000 yields 1000 first.
REQ-034 n_pat=255, IN_BITS=4 -> 255 valid patterns, the sequence repeats every 15, and done occurs exactly once.
